reaction_timer_multi: RTL and testbench

- Parametrised successor of the single-shot reaction benchmark, built on the same clk-domain design.
- Waits a pseudo-random foreperiod after a start pulse, then raises `react` and counts elapsed milliseconds in BCD until the user responds.
- Additional behaviour: configurable clock rate, configurable digit count, random delay from an LFSR, false-start detection, a best-time register, and a multiplexed display scan.
- Sits between the debounced button synchronisers and the 7-segment decoder.

---
 rtl/reaction_timer_multi.sv | 167 ++++++++++++++++
 tb/tb_reaction_timer_multi.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer_multi.sv
// Multi-round reaction timer: random foreperiod, BCD ms count,
// false-start detection, best-time register and display scan.
module reaction_timer_multi #(
    parameter int          CLKS_PER_MS  = 50000,
    parameter int          DIGITS       = 4,
    parameter int          MIN_DELAY_MS = 1000,
    parameter int          RAND_BITS    = 11,
    parameter int          SCAN_DIV     = 1,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_trigger,
    input  logic                        user_trigger,
    input  logic                        show_best,
    output logic                        react,
    output logic                        false_start,
    output logic                        overflow,
    output logic                        best_valid,
    output logic [3:0]                  ms,
    output logic [$clog2(DIGITS)-1:0]   display_select
);

    localparam int PW   = $clog2(CLKS_PER_MS);
    localparam int DMAX = MIN_DELAY_MS + (1 << RAND_BITS) - 1;
    localparam int DW   = (DMAX < 1) ? 1 : $clog2(DMAX + 1);
    localparam int SDW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW   = $clog2(DIGITS);
    localparam int RW   = 4 * DIGITS;
    localparam logic [RW-1:0] ALL9 = {DIGITS{4'h9}};

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_REACT, S_SHOW, S_FOUL
    } state_t;

    state_t          state;
    logic [15:0]     lfsr;
    logic [PW-1:0]   presc;
    logic [DW-1:0]   delay;
    logic [RW-1:0]   result;
    logic [RW-1:0]   best;
    logic [RW-1:0]   src;
    logic [SDW-1:0]  scnt;
    logic [SW-1:0]   sel_next;
    logic [DW-1:0]   delay_load;
    logic            tc;

    assign tc         = (presc == PW'(CLKS_PER_MS - 1));
    assign delay_load = DW'(MIN_DELAY_MS) + DW'(lfsr[RAND_BITS-1:0]);
    assign src        = show_best ? best : result;
    assign sel_next   = (display_select == SW'(DIGITS - 1)) ?
                        '0 : display_select + 1'b1;

    // Ripple-carry BCD increment; caller guards the all-9s case.
    function automatic logic [RW-1:0] bcd_inc(input logic [RW-1:0] v);
        logic [RW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Free-running Fibonacci LFSR, taps 16,14,13,11.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Round FSM with prescaler, delay, result, best and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            presc       <= '0;
            delay       <= '0;
            result      <= '0;
            best        <= ALL9;
            best_valid  <= 1'b0;
            overflow    <= 1'b0;
            react       <= 1'b0;
            false_start <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_SHOW, S_FOUL: begin
                    if (start_trigger) begin
                        state       <= S_WAIT;
                        presc       <= '0;
                        delay       <= delay_load;
                        false_start <= 1'b0;
                        if (state == S_SHOW) begin
                            result   <= '0;
                            overflow <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (user_trigger) begin
                        state       <= S_FOUL;
                        false_start <= 1'b1;
                    end else if (tc) begin
                        presc <= '0;
                        if (delay <= DW'(1)) begin
                            state  <= S_REACT;
                            react  <= 1'b1;
                            result <= '0;
                        end else begin
                            delay <= delay - 1'b1;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                S_REACT: begin
                    if (user_trigger) begin
                        state <= S_SHOW;
                        react <= 1'b0;
                        if (result < best) begin
                            best       <= result;
                            best_valid <= 1'b1;
                        end
                    end else if (tc) begin
                        presc <= '0;
                        if (result == ALL9) begin
                            overflow <= 1'b1;
                        end else begin
                            result <= bcd_inc(result);
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    react <= 1'b0;
                end
            endcase
        end
    end

    // Display scan: step the digit index and fetch its digit together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scnt           <= '0;
            display_select <= '0;
            ms             <= 4'd0;
        end else if (scnt == SDW'(SCAN_DIV - 1)) begin
            scnt           <= '0;
            display_select <= sel_next;
            ms             <= src[{sel_next, 2'b00} +: 4];
        end else begin
            scnt <= scnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Directed bench for reaction_timer_multi: rounds, foul,
// saturation with two digits, and reset mid-round.
module tb_reaction_timer_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_trigger = 1'b0;
    logic       user_trigger  = 1'b0;
    logic       show_best     = 1'b0;
    logic       react, false_start, overflow, best_valid;
    logic [3:0] ms;
    logic [1:0] display_select;

    logic       s2 = 1'b0;
    logic       u2 = 1'b0;
    logic       sb2 = 1'b0;
    logic       react2, fs2, ovf2, bv2;
    logic [3:0] ms2;
    logic [0:0] sel2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reaction_timer_multi #(
        .CLKS_PER_MS(4), .DIGITS(4), .MIN_DELAY_MS(2),
        .RAND_BITS(2), .SCAN_DIV(1), .LFSR_SEED(16'hACE1)
    ) u_dut (
        .clk(clk), .rst(rst),
        .start_trigger(start_trigger), .user_trigger(user_trigger),
        .show_best(show_best), .react(react),
        .false_start(false_start), .overflow(overflow),
        .best_valid(best_valid), .ms(ms),
        .display_select(display_select)
    );

    reaction_timer_multi #(
        .CLKS_PER_MS(4), .DIGITS(2), .MIN_DELAY_MS(2),
        .RAND_BITS(2), .SCAN_DIV(1), .LFSR_SEED(16'hACE1)
    ) u_d2 (
        .clk(clk), .rst(rst),
        .start_trigger(s2), .user_trigger(u2),
        .show_best(sb2), .react(react2),
        .false_start(fs2), .overflow(ovf2),
        .best_valid(bv2), .ms(ms2),
        .display_select(sel2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input int which);
        if (which == 0) start_trigger = 1'b1; else s2 = 1'b1;
        @(negedge clk);
        start_trigger = 1'b0;
        s2 = 1'b0;
    endtask

    task automatic pulse_user(input int which);
        if (which == 0) user_trigger = 1'b1; else u2 = 1'b1;
        @(negedge clk);
        user_trigger = 1'b0;
        u2 = 1'b0;
    endtask

    // Called on the negedge right after the start edge.
    task automatic wait_react(input string tag, input int which);
        int   cyc;
        logic fs_seen;
        logic r;
        cyc = 0;
        fs_seen = 1'b0;
        r = (which == 0) ? react : react2;
        while (!r && cyc < 40) begin
            @(negedge clk);
            cyc++;
            r = (which == 0) ? react : react2;
            if (((which == 0) ? false_start : fs2) === 1'b1) fs_seen = 1'b1;
        end
        chk({tag, "_latency"}, 32'(cyc >= 8 && cyc <= 20), 32'd1);
        chk({tag, "_no_foul"}, 32'(fs_seen), 32'd0);
    endtask

    task automatic scan_check(input string tag, input int which,
                              input logic [15:0] expv);
        int nd;
        int prev;
        int sel;
        logic [3:0] m;
        nd = (which == 0) ? 4 : 2;
        prev = (which == 0) ? int'(display_select) : int'(sel2);
        for (int i = 0; i < nd; i++) begin
            @(negedge clk);
            sel = (which == 0) ? int'(display_select) : int'(sel2);
            m = (which == 0) ? ms : ms2;
            chk({tag, "_sel"}, 32'(sel), 32'((prev + 1) % nd));
            chk({tag, "_ms"}, 32'(m), 32'((expv >> (4 * sel)) & 16'hF));
            prev = sel;
        end
    endtask

    task automatic round(input string tag, input int resp,
                         input logic [15:0] res, input logic [15:0] bst);
        pulse_start(0);
        wait_react(tag, 0);
        repeat (resp) @(negedge clk);
        pulse_user(0);
        chk({tag, "_react_low"}, 32'(react), 32'd0);
        chk({tag, "_best_valid"}, 32'(best_valid), 32'd1);
        show_best = 1'b0;
        @(negedge clk);
        scan_check({tag, "_result"}, 0, res);
        show_best = 1'b1;
        @(negedge clk);
        scan_check({tag, "_best"}, 0, bst);
        show_best = 1'b0;
    endtask

    initial begin
        logic seen;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_react", 32'(react), 32'd0);
        chk("rst_false_start", 32'(false_start), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_best_valid", 32'(best_valid), 32'd0);
        chk("rst_ms", 32'(ms), 32'd0);
        chk("rst_sel", 32'(display_select), 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        round("r1", 148, 16'h0037, 16'h0037);
        round("r2", 160, 16'h0040, 16'h0037);
        round("r3", 120, 16'h0030, 16'h0030);

        pulse_start(0);
        repeat (3) @(negedge clk);
        pulse_user(0);
        chk("foul_flag", 32'(false_start), 32'd1);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (react) seen = 1'b1;
        end
        chk("foul_no_react", 32'(seen), 32'd0);
        chk("foul_flag_held", 32'(false_start), 32'd1);
        show_best = 1'b1;
        @(negedge clk);
        scan_check("foul_best", 0, 16'h0030);
        pulse_start(0);
        chk("restart_clear_foul", 32'(false_start), 32'd0);
        chk("restart_react_low", 32'(react), 32'd0);
        wait_react("r4", 0);
        repeat (20) @(negedge clk);

        #2 rst = 1'b0;
        #1;
        chk("mid_rst_react", 32'(react), 32'd0);
        chk("mid_rst_best_valid", 32'(best_valid), 32'd0);
        chk("mid_rst_ms", 32'(ms), 32'd0);
        chk("mid_rst_sel", 32'(display_select), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        scan_check("mid_rst_best9", 0, 16'h9999);
        show_best = 1'b0;

        start_trigger = 1'b1;
        user_trigger  = 1'b1;
        @(negedge clk);
        start_trigger = 1'b0;
        user_trigger  = 1'b0;
        chk("both_no_foul", 32'(false_start), 32'd0);
        wait_react("both", 0);

        pulse_start(1);
        wait_react("d2", 1);
        repeat (450) @(negedge clk);
        chk("d2_overflow", 32'(ovf2), 32'd1);
        chk("d2_react_held", 32'(react2), 32'd1);
        scan_check("d2_sat", 1, 16'h0099);
        pulse_user(1);
        chk("d2_show_react_low", 32'(react2), 32'd0);
        chk("d2_tie_no_best", 32'(bv2), 32'd0);
        chk("d2_overflow_show", 32'(ovf2), 32'd1);
        scan_check("d2_show", 1, 16'h0099);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
